// File: rtl/asteroids_pkg.sv
// rtl/asteroids_pkg.sv - shared constants, direction/velocity helper and FSM states for the shot pool
//
// Purpose: common definitions imported by shot_manager and its helpers.
//   - screen dimension defaults
//   - direction encoding (clockwise from north, +y points down)
//   - shot speed constants and a direction -> (dx,dy) velocity lookup
//   - shot_manager FSM state encoding
package asteroids_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam int SHOT_SPEED = 4;
  localparam int DIAG_SPEED = 3;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DRAW_REQ,
    ST_DRAW_WAIT,
    ST_DONE
  } shot_state_e;

  typedef struct packed {
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } shot_vel_t;

  // Axis directions move by 'speed', diagonals by DIAG_SPEED on each axis.
  function automatic shot_vel_t shot_vel(input logic [2:0] dir, input logic signed [3:0] speed);
    shot_vel_t         v;
    logic signed [3:0] dg;
    dg   = 4'(DIAG_SPEED);
    v.dx = '0;
    v.dy = '0;
    case (dir)
      DIR_N:  v.dy = -speed;
      DIR_NE: begin v.dx =  dg; v.dy = -dg; end
      DIR_E:  v.dx = speed;
      DIR_SE: begin v.dx =  dg; v.dy =  dg; end
      DIR_S:  v.dy = speed;
      DIR_SW: begin v.dx = -dg; v.dy =  dg; end
      DIR_W:  v.dx = -speed;
      DIR_NW: begin v.dx = -dg; v.dy = -dg; end
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wrap_add.sv
// rtl/wrap_add.sv - position plus signed velocity with single-step wrap into [0, modulus)
//
// Purpose: one axis of a shot move. The sum is formed in signed 11 bits; one
// modulus is subtracted on overflow or added on underflow, which is enough
// because |velocity| is far smaller than the modulus.
// Ports:
//   pos_i  current position (< mod_i)
//   vel_i  signed per-frame velocity
//   mod_i  wrap modulus (screen width or height)
//   pos_o  wrapped position
module wrap_add (
  input  logic        [9:0] pos_i,
  input  logic signed [3:0] vel_i,
  input  logic        [9:0] mod_i,
  output logic        [9:0] pos_o
);

  logic signed [10:0] sum;
  logic signed [10:0] mod_s;

  always_comb begin
    mod_s = signed'({1'b0, mod_i});
    sum   = signed'({1'b0, pos_i}) + 11'(vel_i);
    if (sum >= mod_s) begin
      pos_o = 10'(sum - mod_s);
    end else if (sum < 0) begin
      pos_o = 10'(sum + mod_s);
    end else begin
      pos_o = sum[9:0];
    end
  end

endmodule

// File: rtl/shot_manager.sv
// rtl/shot_manager.sv - live player shot pool: allocate, move/age per frame, sequence sprite draws
//
// Purpose: holds NUM_SHOTS shot slots. A fire allocates the lowest free slot
// (deferred through a one-deep pending register while busy). Each frame_tick
// walks the slots once to move/age them, then walks them again issuing one
// shot_plot per live shot and waiting for shot_draw_done between plots.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   frame_tick                       start of frame update (pulse)
//   fire, fire_x, fire_y, fire_dir   new shot request and its spawn state
//   kill_valid, kill_idx             clear one slot (out-of-range index ignored)
//   shot_draw_done                   drawer finished the current sprite
//   shot_plot, shot_x_pos,
//   shot_y_pos, shot_sprite_sel      one-cycle draw request and its sprite data
//   active_mask                      registered live-slot bitmap
//   busy                             FSM not in IDLE
//   frame_done                       one-cycle pulse when the frame's draws are complete
//   overrun                          sticky: frame_tick seen while busy
module shot_manager
  import asteroids_pkg::*;
#(
  parameter int NUM_SHOTS = 4,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int LIFETIME  = 60,
  parameter int SPEED     = SHOT_SPEED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 fire,
  input  logic [9:0]           fire_x,
  input  logic [9:0]           fire_y,
  input  logic [2:0]           fire_dir,
  input  logic                 kill_valid,
  input  logic [2:0]           kill_idx,
  input  logic                 shot_draw_done,
  output logic                 shot_plot,
  output logic [9:0]           shot_x_pos,
  output logic [9:0]           shot_y_pos,
  output logic [2:0]           shot_sprite_sel,
  output logic [NUM_SHOTS-1:0] active_mask,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int            IW       = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SHOTS - 1);

  shot_state_e          state_q;
  logic [IW-1:0]        idx_q;
  logic [NUM_SHOTS-1:0] active_q;
  logic [9:0]           x_q    [NUM_SHOTS];
  logic [9:0]           y_q    [NUM_SHOTS];
  logic [2:0]           dir_q  [NUM_SHOTS];
  logic [7:0]           life_q [NUM_SHOTS];

  logic                 pend_q;
  logic [9:0]           pend_x_q;
  logic [9:0]           pend_y_q;
  logic [2:0]           pend_dir_q;

  logic                 plot_q;
  logic [9:0]           out_x_q;
  logic [9:0]           out_y_q;
  logic [2:0]           out_sel_q;
  logic                 frame_done_q;
  logic                 overrun_q;

  logic                 alloc_req_d;
  logic                 alloc_ok_d;
  logic [IW-1:0]        alloc_slot_d;
  logic [9:0]           alloc_x_d;
  logic [9:0]           alloc_y_d;
  logic [2:0]           alloc_dir_d;
  logic                 kill_ok_d;
  logic [IW-1:0]        kill_slot_d;
  shot_vel_t            vel_d;
  logic [9:0]           upd_x_d;
  logic [9:0]           upd_y_d;

  // A deferred fire takes priority over a fresh one; the fresh one is then
  // re-queued into the pending register.
  always_comb begin
    alloc_req_d  = (state_q == ST_IDLE) && (pend_q || fire);
    alloc_x_d    = pend_q ? pend_x_q   : fire_x;
    alloc_y_d    = pend_q ? pend_y_q   : fire_y;
    alloc_dir_d  = pend_q ? pend_dir_q : fire_dir;
    alloc_ok_d   = 1'b0;
    alloc_slot_d = '0;
    // Descending scan so the lowest free slot is the one left selected.
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        alloc_ok_d   = 1'b1;
        alloc_slot_d = IW'(i);
      end
    end
  end

  always_comb begin
    kill_ok_d   = kill_valid && ({1'b0, kill_idx} < 4'(NUM_SHOTS));
    kill_slot_d = kill_idx[IW-1:0];
    vel_d       = shot_vel(dir_q[idx_q], 4'(SPEED));
  end

  wrap_add u_wrap_x (
    .pos_i (x_q[idx_q]),
    .vel_i (vel_d.dx),
    .mod_i (10'(SCREEN_W)),
    .pos_o (upd_x_d)
  );

  wrap_add u_wrap_y (
    .pos_i (y_q[idx_q]),
    .vel_i (vel_d.dy),
    .mod_i (10'(SCREEN_H)),
    .pos_o (upd_y_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      active_q     <= '0;
      pend_q       <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_dir_q   <= '0;
      plot_q       <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_sel_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        dir_q[i]  <= '0;
        life_q[i] <= '0;
      end
    end else begin
      plot_q       <= 1'b0;
      frame_done_q <= 1'b0;

      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (alloc_req_d && alloc_ok_d) begin
            active_q[alloc_slot_d] <= 1'b1;
            x_q[alloc_slot_d]      <= alloc_x_d;
            y_q[alloc_slot_d]      <= alloc_y_d;
            dir_q[alloc_slot_d]    <= alloc_dir_d;
            life_q[alloc_slot_d]   <= 8'(LIFETIME);
          end
          if (pend_q) begin
            pend_q     <= fire;
            pend_x_q   <= fire_x;
            pend_y_q   <= fire_y;
            pend_dir_q <= fire_dir;
          end
          if (frame_tick) begin
            state_q <= ST_UPDATE;
            idx_q   <= '0;
          end
        end

        ST_UPDATE: begin
          if (active_q[idx_q]) begin
            if (life_q[idx_q] == 8'd1) begin
              active_q[idx_q] <= 1'b0;
              life_q[idx_q]   <= 8'd0;
            end else begin
              life_q[idx_q] <= life_q[idx_q] - 8'd1;
              x_q[idx_q]    <= upd_x_d;
              y_q[idx_q]    <= upd_y_d;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DRAW_REQ;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_DRAW_REQ: begin
          if (active_q[idx_q]) begin
            plot_q    <= 1'b1;
            out_x_q   <= x_q[idx_q];
            out_y_q   <= y_q[idx_q];
            out_sel_q <= dir_q[idx_q];
            state_q   <= ST_DRAW_WAIT;
          end else if (idx_q == LAST_IDX) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_DRAW_WAIT: begin
          if (shot_draw_done) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_DRAW_REQ;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

      if ((state_q != ST_IDLE) && fire && !pend_q) begin
        pend_q     <= 1'b1;
        pend_x_q   <= fire_x;
        pend_y_q   <= fire_y;
        pend_dir_q <= fire_dir;
      end

      // Last assignment wins: a kill overrides any same-cycle allocate/update.
      if (kill_ok_d) begin
        active_q[kill_slot_d] <= 1'b0;
      end
    end
  end

  assign shot_plot       = plot_q;
  assign shot_x_pos      = out_x_q;
  assign shot_y_pos      = out_y_q;
  assign shot_sprite_sel = out_sel_q;
  assign active_mask     = active_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = frame_done_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_shot_manager.sv
// tb/tb_shot_manager.sv - self-checking bench for shot_manager against a frame-level shot pool model
module tb_shot_manager;

  localparam int NS   = 4;
  localparam int W    = 320;
  localparam int H    = 240;
  localparam int LIFE = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          fire = 1'b0;
  logic [9:0]    fire_x = '0;
  logic [9:0]    fire_y = '0;
  logic [2:0]    fire_dir = '0;
  logic          kill_valid = 1'b0;
  logic [2:0]    kill_idx = '0;
  logic          shot_draw_done = 1'b0;
  logic          shot_plot;
  logic [9:0]    shot_x_pos;
  logic [9:0]    shot_y_pos;
  logic [2:0]    shot_sprite_sel;
  logic [NS-1:0] active_mask;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  shot_manager #(
    .NUM_SHOTS (NS),
    .SCREEN_W  (W),
    .SCREEN_H  (H),
    .LIFETIME  (LIFE),
    .SPEED     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .fire            (fire),
    .fire_x          (fire_x),
    .fire_y          (fire_y),
    .fire_dir        (fire_dir),
    .kill_valid      (kill_valid),
    .kill_idx        (kill_idx),
    .shot_draw_done  (shot_draw_done),
    .shot_plot       (shot_plot),
    .shot_x_pos      (shot_x_pos),
    .shot_y_pos      (shot_y_pos),
    .shot_sprite_sel (shot_sprite_sel),
    .active_mask     (active_mask),
    .busy            (busy),
    .frame_done      (frame_done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Frame-level model of the pool: whole-frame moves with modulo wrap.
  typedef struct { int x; int y; int d; } plot_t;
  int    m_x [NS];
  int    m_y [NS];
  int    m_dir [NS];
  int    m_life [NS];
  bit    m_act [NS];
  bit    m_pend = 0;
  int    m_px, m_py, m_pdir;
  bit    m_overrun = 0;
  bit    mask_valid = 0;
  plot_t exp_q [$];
  int    dxs [8] = '{0, 3, 4, 3, 0, -3, -4, -3};
  int    dys [8] = '{-4, -3, 0, 3, 4, 3, 0, -3};

  function automatic int m_mask();
    int r = 0;
    for (int i = 0; i < NS; i++) if (m_act[i]) r |= (1 << i);
    return r;
  endfunction

  task automatic m_alloc(input int x, input int y, input int d);
    for (int i = 0; i < NS; i++) begin
      if (!m_act[i]) begin
        m_act[i] = 1; m_x[i] = x; m_y[i] = y; m_dir[i] = d; m_life[i] = LIFE;
        return;
      end
    end
  endtask

  task automatic m_kill(input int k);
    if (k < NS) m_act[k] = 0;
  endtask

  task automatic m_frame();
    plot_t p;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        if (m_life[i] == 1) m_act[i] = 0;
        else begin
          m_life[i]--;
          m_x[i] = (m_x[i] + dxs[m_dir[i]] + W) % W;
          m_y[i] = (m_y[i] + dys[m_dir[i]] + H) % H;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        p.x = m_x[i]; p.y = m_y[i]; p.d = m_dir[i];
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_act[i] = 0;
    m_pend = 0; m_overrun = 0; exp_q.delete();
  endtask

  // Drawer stand-in: answers each plot with draw_done resp_delay cycles later.
  int resp_delay = 36;
  bit resp_mute  = 0;
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      shot_draw_done = 1'b0;
      if (reset) cnt = 0;
      else if (shot_plot) cnt = resp_delay;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !resp_mute) shot_draw_done = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  int cyc = 0;
  int tick_cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  bit first_plot = 0;
  int lp_x, lp_y, lp_d;
  initial begin
    plot_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        if (shot_plot) begin
          plot_cnt++;
          lp_x = shot_x_pos; lp_y = shot_y_pos; lp_d = shot_sprite_sel;
          check("plot_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("plot_x", shot_x_pos, e.x);
            check("plot_y", shot_y_pos, e.y);
            check("plot_sel", shot_sprite_sel, e.d);
          end
          if (first_plot) begin
            first_plot = 0;
            check("plot_latency", (cyc - tick_cyc) >= NS + 1, 1);
          end
        end
        if (frame_done) begin
          done_cnt++;
          check("done_all_drawn", exp_q.size(), 0);
        end
        check("overrun", overrun, m_overrun);
        if (mask_valid) check("mask", active_mask, m_mask());
      end
    end
  end

  task automatic do_fire(input int x, input int y, input int d);
    @(negedge clk);
    fire = 1; fire_x = 10'(x); fire_y = 10'(y); fire_dir = 3'(d);
    m_alloc(x, y, d);
    @(negedge clk);
    fire = 0;
  endtask

  task automatic do_kill(input int k);
    @(negedge clk);
    kill_valid = 1; kill_idx = 3'(k);
    m_kill(k);
    @(negedge clk);
    kill_valid = 0;
  endtask

  task automatic do_fire_kill(input int x, input int y, input int d, input int k);
    @(negedge clk);
    fire = 1; fire_x = 10'(x); fire_y = 10'(y); fire_dir = 3'(d);
    kill_valid = 1; kill_idx = 3'(k);
    m_alloc(x, y, d);
    m_kill(k);
    @(negedge clk);
    fire = 0; kill_valid = 0;
  endtask

  task automatic kill_all();
    for (int k = 0; k < NS; k++) do_kill(k);
  endtask

  task automatic queue_busy_fire(input int x, input int y, input int d);
    fire = 1; fire_x = 10'(x); fire_y = 10'(y); fire_dir = 3'(d);
    if (!m_pend) begin m_pend = 1; m_px = x; m_py = y; m_pdir = d; end
  endtask

  // One frame. fire_same: fire in the tick cycle. inj: cycle after tick to
  // inject a busy fire (0 = none). ovr: at the first plot, tick again, fire
  // and kill slot 0 while the draw is outstanding.
  task automatic run_frame(input bit fire_same, input int inj,
                           input int x, input int y, input int d, input bit ovr);
    int n;
    bit ovr_done;
    ovr_done = 0;
    @(negedge clk);
    frame_tick = 1; mask_valid = 0; tick_cyc = cyc; first_plot = 1;
    if (fire_same) begin
      fire = 1; fire_x = 10'(x); fire_y = 10'(y); fire_dir = 3'(d);
      m_alloc(x, y, d);
    end
    m_frame();
    @(negedge clk);
    frame_tick = 0; fire = 0;
    n = 1;
    while (frame_done !== 1'b1 && n < 3000) begin
      fire = 0; frame_tick = 0; kill_valid = 0;
      if (n == inj) queue_busy_fire(x, y, d);
      if (ovr && !ovr_done && shot_plot === 1'b1) begin
        ovr_done = 1;
        frame_tick = 1; m_overrun = 1;
        kill_valid = 1; kill_idx = 3'd0; m_kill(0);
        queue_busy_fire(x, y, d);
      end
      @(negedge clk);
      n++;
    end
    fire = 0; frame_tick = 0; kill_valid = 0;
    check("frame_done_seen", frame_done, 1);
    @(negedge clk);
    check("busy_idle", busy, 0);
    if (m_pend) begin
      m_pend = 0;
      m_alloc(m_px, m_py, m_pdir);
    end
    mask_valid = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_plot"}, shot_plot, 0);
    check({tag, "_x"}, shot_x_pos, 0);
    check({tag, "_y"}, shot_y_pos, 0);
    check({tag, "_sel"}, shot_sprite_sel, 0);
    check({tag, "_mask"}, active_mask, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int p0, d0, n, op;
    m_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    mask_valid = 1;

    // Single east shot, 36-cycle drawer.
    do_fire(100, 50, 2);
    check("mask_first", active_mask, 1);
    d0 = done_cnt;
    run_frame(0, 0, 0, 0, 0, 0);
    check("e_x", lp_x, 104);
    check("e_y", lp_y, 50);
    check("e_sel", lp_d, 2);
    check("e_done_once", done_cnt - d0, 1);
    kill_all();

    // Both axes wrap.
    resp_delay = 3;
    do_fire(318, 0, 1);
    run_frame(0, 0, 0, 0, 0, 0);
    check("ne_x", lp_x, 1);
    check("ne_y", lp_y, 237);
    kill_all();

    // Pool full, fifth dropped, killed slot reused.
    for (int i = 0; i < 5; i++) do_fire(10 * i, 20 + i, i);
    check("mask_full", active_mask, 4'hF);
    do_kill(1);
    do_fire(200, 200, 7);
    check("mask_reuse", active_mask, 4'hF);
    run_frame(0, 0, 0, 0, 0, 0);
    kill_all();

    // Same-cycle kill and fire: allocation ignores the freed slot.
    for (int i = 0; i < 3; i++) do_fire(50, 60, 4);
    do_fire_kill(70, 80, 3, 0);
    check("mask_kill_fire", active_mask, 4'hE);
    kill_all();

    // Fire and tick together: new shot moves this frame.
    run_frame(1, 0, 10, 10, 6, 0);
    check("ft_x", lp_x, 6);
    check("ft_y", lp_y, 10);
    kill_all();

    // Lifetime: drawn in LIFE-1 frames, gone in frame LIFE.
    do_fire(5, 5, 3);
    p0 = plot_cnt;
    for (int f = 0; f < LIFE; f++) begin
      resp_delay = $urandom_range(1, 4);
      run_frame(0, 0, 0, 0, 0, 0);
    end
    check("life_plots", plot_cnt - p0, LIFE - 1);
    check("life_mask", active_mask, 0);
    p0 = plot_cnt;
    run_frame(0, 0, 0, 0, 0, 0);
    check("life_after", plot_cnt - p0, 0);

    // Overrun, fire and kill during DRAW_WAIT.
    resp_delay = 10;
    do_fire(30, 40, 0);
    run_frame(0, 0, 123, 45, 5, 1);
    check("ovr_sticky", overrun, 1);
    @(negedge clk);
    check("ovr_mask", active_mask, 1);

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) do_fire($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
      else if (op == 4) do_kill($urandom_range(0, 7));
      else begin
        resp_delay = $urandom_range(1, 8);
        run_frame($urandom_range(0, 3) == 0, ($urandom_range(0, 1) == 1) ? $urandom_range(1, NS) : 0,
                  $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0);
      end
    end

    // Reset while waiting on a draw that never completes.
    kill_all();
    do_fire(200, 120, 4);
    resp_mute = 1;
    @(negedge clk);
    frame_tick = 1; mask_valid = 0; tick_cyc = cyc; first_plot = 1;
    m_frame();
    @(negedge clk);
    frame_tick = 0;
    n = 0;
    while (shot_plot !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("plot_before_reset", shot_plot, 1);
    repeat (2) @(negedge clk);
    check("busy_in_wait", busy, 1);
    reset = 1;
    m_reset();
    @(negedge clk);
    check_zero("rst_mid");
    reset = 0; resp_mute = 0; mask_valid = 1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_manager.md
Name: shot_manager

Overview:
Owns the pool of live player shots and sits directly upstream of the shot sprite drawer. It allocates a slot on fire, then on each frame tick advances every live shot by its direction velocity with screen wrap-around and ages it. It then walks the slots and issues one plot request per live shot to the drawer, waiting for that drawer's draw_done before issuing the next.

Parameters:
NUM_SHOTS, 4, number of shot slots (2..8)
SCREEN_W, 320, horizontal wrap modulus in pixels
SCREEN_H, 240, vertical wrap modulus in pixels
LIFETIME, 60, frames a shot lives after firing (1..255)
SPEED, 4, pixels per frame on axis directions; diagonals use 3 per axis

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, start of frame update
fire  in  1  one-cycle pulse, request new shot
fire_x  in  10  spawn x, < SCREEN_W
fire_y  in  10  spawn y, < SCREEN_H
fire_dir  in  3  direction: 0=N, 1=NE, 2=E … 7=NW, clockwise
kill_valid  in  1  collision kill strobe
kill_idx  in  3  slot to kill
shot_draw_done  in  1  drawer finished current sprite (pulse)
shot_plot  out  1  one-cycle draw request to drawer
shot_x_pos  out  10  sprite x to drawer
shot_y_pos  out  10  sprite y to drawer
shot_sprite_sel  out  3  direction of shot being drawn
active_mask  out  NUM_SHOTS  live-slot bitmap
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse, frame's draws complete
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset: all outputs 0; all slots inactive; FSM in IDLE; pending-fire cleared. Reset mid-draw abandons the draw and does not wait for draw_done.
- FSM states: IDLE, UPDATE, DRAW_REQ, DRAW_WAIT, DONE.
- IDLE -> UPDATE on frame_tick; idx=0. frame_tick outside IDLE is dropped and sets overrun.
- UPDATE: one slot per cycle for NUM_SHOTS cycles. For an active slot: life-1; if life was 1, clear active. Otherwise pos += vel with wrap:
  - Sum in signed 11 bits.
  - If sum >= SCREEN_W (or SCREEN_H), subtract the modulus; if sum < 0, add the modulus.
  - Inactive slots are unchanged. Then go to DRAW_REQ with idx=0.
- Velocity LUT (dx,dy), +y down:
  - N (0,-S), E (+S,0), S (0,+S), W (-S,0).
  - Diagonals (±3,±3).
- DRAW_REQ: if slot idx is active, drive shot_x_pos/y_pos/sprite_sel from the slot, pulse shot_plot for exactly one cycle, go to DRAW_WAIT. If inactive, idx++ and stay (1 cycle per empty slot). After the last idx, go to DONE.
- DRAW_WAIT: hold x/y/sprite_sel stable. On shot_draw_done: idx++, go to DRAW_REQ (or DONE if idx was last). No timeout.
- DONE: frame_done=1 for one cycle, then IDLE.
- Latency: frame_tick at cycle T -> first shot_plot no earlier than T+NUM_SHOTS+1.
- Fire:
  - In IDLE, allocate the lowest inactive slot: pos=fire_x/y, dir=fire_dir, life=LIFETIME, active=1. Takes effect the next cycle.
  - When not IDLE, latch into a one-deep pending register; apply it on the first IDLE cycle. A fire while pending is already set is dropped.
  - No free slot: the fire is dropped silently.
  - fire and frame_tick in the same IDLE cycle: allocate first; the new shot is updated in this frame.
- Kill: clears active[kill_idx] at the clock edge, in any state; kill_idx >= NUM_SHOTS is ignored.
  - Kill of the slot in DRAW_WAIT: the draw still completes.
  - Kill and fire in the same cycle: allocation uses the pre-kill mask, so the killed slot is not reused that cycle.
- active_mask is the registered active bits.

Decomposition:
- Shared package asteroids_pkg holds:
  - direction encoding constants DIR_N..DIR_NW
  - shot velocity LUT constants (SPEED, DIAG_SPEED)
  - FSM state encoding
  - screen dimension constants
- One natural combinational sub-module, wrap_add: 10-bit position + signed 4-bit velocity + modulus -> wrapped 10-bit position. It is instanced twice (x and y).

Test Plan:
- Fire at (100,50) dir E, then frame_tick, then respond to each shot_plot with shot_draw_done after 36 cycles -> one shot_plot with x=104, y=50, sprite_sel=2; frame_done once; busy back to 0.
- Fire at (318,0) dir NE, frame_tick -> drawn at x=1, y=237 (both axes wrap).
- 5 fires with NUM_SHOTS=4 -> active_mask=4'b1111, fifth dropped; kill_idx=1 then fire -> slot 1 reused, mask 1111.
- LIFETIME=2, fire, 3 frame_ticks -> drawn in frames 1 only; frame 2 deactivates (mask 0), no shot_plot in frames 2–3.
- frame_tick while in DRAW_WAIT -> overrun=1 and stays set; fire in DRAW_WAIT -> slot allocated the cycle after return to IDLE.
- reset asserted in DRAW_WAIT with shot_draw_done never sent -> next cycle all outputs 0, mask 0, FSM IDLE.
